switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
//  Separable input-first switch allocator for the router's input-buffer array.
//  Each cycle it picks one VC per input port from the buffers in SA state (switch_request), gated by downstream on/off credit.
//  It then resolves output-port conflicts and drives per-VC read strobes back to the buffers.
//  It also drives registered crossbar selects to the switch-traversal stage.
// PARAMETERS
//  PORT_NUM     5   router ports (noc_params); also input/output port count
//  VC_NUM       2   virtual channels per port (noc_params)
//  CNT_WIDTH    16  width of the stats counters (only with SA_STATS_EN)
// PORTS
//  clk               in   1                        clock
//  rst               in   1                        async reset, active-high
//  request_i         in   [PORT_NUM][VC_NUM]       switch_request from each input buffer
//  out_port_i        in   port_t [PORT_NUM][VC_NUM] output port held by each input buffer
//  downstream_vc_i   in   [PORT_NUM][VC_NUM][VC_SIZE] downstream VC held by each input buffer
//  on_off_i          in   [PORT_NUM][VC_NUM]       downstream on/off per (output port, downstream VC); 1 = may send
//  grant_o           out  [PORT_NUM][VC_NUM]       read strobe to input buffer (drives read_i)
//  xbar_sel_o        out  port_t [PORT_NUM]        per output port: selected input port (registered)
//  valid_flit_o      out  [PORT_NUM]               per output port: flit traverses next cycle (registered)
//  conflict_cnt_o    out  [PORT_NUM][CNT_WIDTH]    stats: lost stage-2 contentions (SA_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, any time): all RR pointers = 0, xbar_sel_o = LOCAL, valid_flit_o = 0, counters = 0.
//    grant_o is combinational and is 0 while rst=1.
//  - Eligibility: eligible[i][v] = request_i[i][v] & on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]].
//    An out_port_i value >= PORT_NUM makes the VC ineligible.
//  - Stage 1, per input port i: round-robin over eligible[i][*], starting at in_ptr[i].
//    Yields winner VC w1[i] and target output t[i].
//  - Stage 2, per output port o: round-robin over input ports with a stage-1 winner and t[i]==o, starting at out_ptr[o].
//  - grant_o[i][w1[i]] = 1, same cycle, iff input i wins stage 2 (zero latency, combinational from registered ptrs).
//    At most one grant per input port and per output port.
//  - Pointer update, posedge clk, only on a final grant:
//    in_ptr[i] <= (w1[i]+1) mod VC_NUM; out_ptr[o] <= (winner+1) mod PORT_NUM. Both wrap to 0.
//    A stage-1 winner that loses stage 2 does NOT advance in_ptr[i].
//  - Registered outputs, one cycle after the grant:
//    valid_flit_o[o] <= any grant to o; xbar_sel_o[o] <= winning input (held when no grant).
//  - No requests: grant_o = 0 and pointers hold.
//    All requests ineligible (on_off=0): same, with no grant.
//  - Simultaneous request drop and grant cannot occur (grant is combinational from current request).
//  - Starvation-free: a continuously eligible VC is granted within PORT_NUM*VC_NUM cycles.
// CONFIGURATION
//  - SA_STATS_EN defined: per output port o, conflict_cnt_o[o] += (number of stage-1 winners targeting o) - 1 when >= 2.
//    The counter saturates at all-ones and resets to 0.
//  - SA_STATS_EN undefined: conflict_cnt_o ties to 0 and no counter flops are built.
// STRUCTURE
//  - noc_params package: PORT_NUM, VC_NUM, VC_SIZE, port_t (LOCAL..), existing.
//    New: localparam PORT_SIZE = $clog2(PORT_NUM).
//  - Sub-module round_robin_arbiter #(N): req[N], update_i, grant one-hot [N], internal ptr.
//    Instantiated PORT_NUM times with N=VC_NUM (stage 1) and PORT_NUM times with N=PORT_NUM (stage 2).
//    update_i = final grant.
// TESTING
//  1. After reset, request_i[0][0]=1, out_port=NORTH, dvc=0, on_off[NORTH][0]=1
//     -> grant_o[0][0]=1 same cycle; next cycle valid_flit_o[NORTH]=1, xbar_sel_o[NORTH]=0.
//  2. Inputs 1 and 2 both target EAST, all on, held 4 cycles -> grants alternate 1,2,1,2; no cycle with both.
//  3. Input 0 VC0 and VC1 target different free ports, held 4 cycles -> VC grants alternate 0,1,0,1.
//     At most one grant per cycle on input 0.
//  4. on_off[SOUTH][1]=0 with request to SOUTH/dvc1 -> no grant.
//     Raise on_off -> grant in the same cycle.
//  5. Assert rst mid-contention (pointers nonzero) -> grant_o=0, valid_flit_o=0 immediately.
//     After release, arbitration restarts at input 0 / VC0.
//  6. SA_STATS_EN: 3 inputs target WEST for 10 cycles -> conflict_cnt_o[WEST]=20.
//     Preload near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Router-wide NoC parameters and port encoding shared by the switch allocator,
// its interface and the bench.
package switch_allocator_pkg;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 0,
        NORTH = 1,
        SOUTH = 2,
        WEST  = 3,
        EAST  = 4
    } port_t;

    // Number of input ports whose stage-1 winner targets one output port.
    function automatic int unsigned count_ones(input logic [PORT_NUM-1:0] bits);
        int unsigned n;
        n = 0;
        for (int k = 0; k < PORT_NUM; k++) begin
            n += 32'(bits[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Bundle between the input-buffer array / traversal stage (master) and the
// switch allocator (slave).
interface switch_allocator_if
    import switch_allocator_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              grant_o;
    port_t [PORT_NUM-1:0]                          xbar_sel_o;
    logic  [PORT_NUM-1:0]                          valid_flit_o;
    logic  [PORT_NUM-1:0][CNT_WIDTH-1:0]           conflict_cnt_o;

    modport master (
        output request_i, out_port_i, downstream_vc_i, on_off_i,
        input  grant_o, xbar_sel_o, valid_flit_o, conflict_cnt_o
    );

    modport slave (
        input  request_i, out_port_i, downstream_vc_i, on_off_i,
        output grant_o, xbar_sel_o, valid_flit_o, conflict_cnt_o
    );

endinterface

// File: rtl/switch_allocator_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer, which
// moves just past the winner only when the caller confirms the grant.
module round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update_i,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;

    // Scan farthest-first so the requester nearest the pointer overwrites the rest.
    always_comb begin
        int idx;
        grant = '0;
        win   = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[IW'(idx)]) begin
                grant          = '0;
                grant[IW'(idx)] = 1'b1;
                win            = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (update_i) begin
            ptr <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with registered crossbar selects.
// Define SA_STATS_EN to build the per-output lost-contention counters.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave sa
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
    logic  [PORT_NUM-1:0]               s1_valid;
    logic  [PORT_NUM-1:0]               in_win;
    port_t [PORT_NUM-1:0]               tgt;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;
    port_t [PORT_NUM-1:0]               s2_winner;

    // Unroutable ports and downstream VCs that are switched off never compete.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (int'(sa.out_port_i[i][v]) < PORT_NUM) begin
                    eligible[i][v] = sa.request_i[i][v] &
                        sa.on_off_i[sa.out_port_i[i][v]][sa.downstream_vc_i[i][v]];
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_vc_arb
        round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk      (clk),
            .rst      (rst),
            .req      (eligible[i]),
            .update_i (in_win[i]),
            .grant    (s1_grant[i])
        );
    end

    always_comb begin
        s1_valid = '0;
        s2_req   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            tgt[i]      = LOCAL;
            s1_valid[i] = |s1_grant[i];
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_grant[i][v]) begin
                    tgt[i] = sa.out_port_i[i][v];
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                s2_req[o][i] = s1_valid[i] && (int'(tgt[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_port_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
            .clk      (clk),
            .rst      (rst),
            .req      (s2_req[o]),
            .update_i (|s2_grant[o]),
            .grant    (s2_grant[o])
        );
    end

    // Only a stage-2 win turns the stage-1 choice into a read strobe.
    always_comb begin
        in_win     = '0;
        sa.grant_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            s2_winner[o] = LOCAL;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (s2_grant[o][i]) begin
                    in_win[i]    = 1'b1;
                    s2_winner[o] = port_t'(PORT_SIZE'(i));
                end
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (in_win[i] && !rst) begin
                sa.grant_o[i] = s1_grant[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa.valid_flit_o <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                sa.xbar_sel_o[o] <= LOCAL;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                sa.valid_flit_o[o] <= |s2_grant[o];
                if (|s2_grant[o]) begin
                    sa.xbar_sel_o[o] <= s2_winner[o];
                end
            end
        end
    end

`ifdef SA_STATS_EN
    logic [PORT_NUM-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [PORT_NUM-1:0][CNT_WIDTH-1:0] cnt_d;

    // Every stage-1 winner beyond the first on an output port lost a contention.
    always_comb begin
        int unsigned    n;
        logic [CNT_WIDTH:0] sum;
        n     = 0;
        sum   = '0;
        cnt_d = cnt_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            n = count_ones(s2_req[o]);
            if (n >= 2) begin
                sum      = {1'b0, cnt_q[o]} + (CNT_WIDTH + 1)'(n - 1);
                cnt_d[o] = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sa.conflict_cnt_o = cnt_q;
`else
    assign sa.conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Table-driven bench for switch_allocator: combinational grants are checked per
// vector, registered crossbar outputs go through a scoreboard queue.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int CNT_WIDTH = 16;

    typedef logic [PORT_NUM-1:0][VC_NUM-1:0] pv_t;

    typedef struct {
        bit                                       rst_before;
        pv_t                                      req;
        logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] port;
        pv_t                                      dvc;
        pv_t                                      on_off;
        pv_t                                      exp_grant;
    } vec_t;

    typedef struct {
        logic [PORT_NUM-1:0]                valid;
        logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel;
    } reg_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    switch_allocator_if #(.CNT_WIDTH(CNT_WIDTH)) sa_if ();

    switch_allocator #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_if)
    );

    vec_t                               tbl[$];
    reg_exp_t                           sb[$];
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_hold;
    int                                 total = 0;
    int                                 bad   = 0;

    function automatic vec_t blank(input bit r);
        vec_t v;
        v.rst_before = r;
        v.req        = '0;
        v.port       = '0;
        v.dvc        = '0;
        v.on_off     = '1;
        v.exp_grant  = '0;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                sa_if.request_i[i][k]       = v.req[i][k];
                sa_if.out_port_i[i][k]      = port_t'(v.port[i][k]);
                sa_if.downstream_vc_i[i][k] = VC_SIZE'(v.dvc[i][k]);
                sa_if.on_off_i[i][k]        = v.on_off[i][k];
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(blank(1'b0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        sel_hold = '0;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        reg_exp_t e;
        if (v.rst_before) do_reset();
        drive(v);
        @(negedge clk);
        check_output({tag, " grant"}, 64'(sa_if.grant_o), 64'(v.exp_grant));
        e.valid = '0;
        e.sel   = sel_hold;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                if (v.exp_grant[i][k]) begin
                    e.valid[v.port[i][k]] = 1'b1;
                    e.sel[v.port[i][k]]   = PORT_SIZE'(i);
                end
            end
        end
        sel_hold = e.sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_output({tag, " valid_flit"}, 64'(sa_if.valid_flit_o), 64'(e.valid));
        check_output({tag, " xbar_sel"}, 64'(sa_if.xbar_sel_o), 64'(e.sel));
    endtask

    initial begin
        vec_t v;
        vec_t g;
        logic [CNT_WIDTH-1:0] exp_west;

        // Reset state, with a live request present to prove grants are masked.
        g = blank(1'b0);
        g.req[0][0]  = 1'b1;
        g.port[0][0] = NORTH;
        drive(g);
        #1 rst = 1'b1;
        #1;
        check_output("reset grant", 64'(sa_if.grant_o), 64'd0);
        check_output("reset valid_flit", 64'(sa_if.valid_flit_o), 64'd0);
        check_output("reset xbar_sel", 64'(sa_if.xbar_sel_o), 64'd0);
        for (int o = 0; o < PORT_NUM; o++) begin
            check_output($sformatf("reset conflict_cnt[%0d]", o), 64'(sa_if.conflict_cnt_o[o]), 64'd0);
        end

        // Single request to NORTH.
        v = blank(1'b1);
        v.req[0][0] = 1'b1; v.port[0][0] = NORTH; v.exp_grant[0][0] = 1'b1;
        tbl.push_back(v);

        // Inputs 1 and 2 fight for EAST: strict alternation 1,2,1,2.
        for (int c = 0; c < 4; c++) begin
            v = blank(1'b0);
            v.req[1][0] = 1'b1; v.port[1][0] = EAST;
            v.req[2][0] = 1'b1; v.port[2][0] = EAST;
            if (c % 2 == 0) v.exp_grant[1][0] = 1'b1;
            else            v.exp_grant[2][0] = 1'b1;
            tbl.push_back(v);
        end

        // Input 0 has two VCs to free ports: VC alternation 0,1,0,1.
        for (int c = 0; c < 4; c++) begin
            v = blank(c == 0);
            v.req[0] = 2'b11; v.port[0][0] = SOUTH; v.port[0][1] = WEST;
            v.exp_grant[0][c % 2] = 1'b1;
            tbl.push_back(v);
        end

        // Downstream VC switched off, then switched back on.
        v = blank(1'b0);
        v.req[3][1] = 1'b1; v.port[3][1] = SOUTH; v.dvc[3][1] = 1'b1;
        v.on_off[SOUTH][1] = 1'b0;
        tbl.push_back(v);
        v.on_off = '1; v.exp_grant[3][1] = 1'b1;
        tbl.push_back(v);

        // Out-of-range ports are never eligible; a valid sibling VC still wins.
        v = blank(1'b0);
        v.req[4] = 2'b11; v.port[4][0] = 3'd5; v.port[4][1] = 3'd7;
        tbl.push_back(v);
        v.port[4][1] = NORTH; v.exp_grant[4][1] = 1'b1;
        tbl.push_back(v);

        // Everything off, then no requests at all.
        v = blank(1'b0);
        for (int i = 0; i < PORT_NUM; i++) begin
            v.req[i][0] = 1'b1; v.port[i][0] = PORT_SIZE'(i);
        end
        v.on_off = '0;
        tbl.push_back(v);
        tbl.push_back(blank(1'b0));

        // Full permutation: every input to a distinct output in one cycle.
        v = blank(1'b0);
        v.req[0][0] = 1'b1; v.port[0][0] = NORTH;
        v.req[1][0] = 1'b1; v.port[1][0] = SOUTH;
        v.req[2][0] = 1'b1; v.port[2][0] = WEST;
        v.req[3][0] = 1'b1; v.port[3][0] = EAST;
        v.req[4][0] = 1'b1; v.port[4][0] = LOCAL;
        for (int i = 0; i < PORT_NUM; i++) v.exp_grant[i][0] = 1'b1;
        tbl.push_back(v);

        for (int n = 0; n < tbl.size(); n++) begin
            apply_stimulus(tbl[n], $sformatf("vec%0d", n));
        end

        // Reset mid-contention with both pointers advanced.
        v = blank(1'b0);
        v.req[0] = 2'b11; v.port[0][0] = EAST; v.port[0][1] = EAST;
        v.req[2][0] = 1'b1; v.port[2][0] = EAST;
        g = v; g.rst_before = 1'b1; g.exp_grant[0][0] = 1'b1;
        apply_stimulus(g, "pre_rst0");
        g = v; g.exp_grant[2][0] = 1'b1;
        apply_stimulus(g, "pre_rst1");
        #1 rst = 1'b1;
        #1;
        check_output("mid_rst grant", 64'(sa_if.grant_o), 64'd0);
        check_output("mid_rst valid_flit", 64'(sa_if.valid_flit_o), 64'd0);
        check_output("mid_rst xbar_sel", 64'(sa_if.xbar_sel_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        sel_hold = '0;
        g = v; g.exp_grant[0][0] = 1'b1;
        apply_stimulus(g, "post_rst0");
        g = v; g.exp_grant[2][0] = 1'b1;
        apply_stimulus(g, "post_rst1");

        // Three-way contention on WEST for ten cycles.
        do_reset();
        v = blank(1'b0);
        for (int i = 1; i <= 3; i++) begin
            v.req[i][0] = 1'b1; v.port[i][0] = WEST;
        end
        drive(v);
        repeat (10) @(posedge clk);
        #1 drive(blank(1'b0));
`ifdef SA_STATS_EN
        exp_west = 16'd20;
`else
        exp_west = 16'd0;
`endif
        for (int o = 0; o < PORT_NUM; o++) begin
            check_output($sformatf("conflict_cnt[%0d]", o), 64'(sa_if.conflict_cnt_o[o]),
                         (o == int'(WEST)) ? 64'(exp_west) : 64'd0);
        end

`ifdef SA_STATS_EN
        // Five-way contention adds four per cycle: walk up to the all-ones ceiling.
        v = blank(1'b0);
        for (int i = 0; i < PORT_NUM; i++) begin
            v.req[i][0] = 1'b1; v.port[i][0] = WEST;
        end
        drive(v);
        repeat (16378) @(posedge clk);
        #1;
        check_output("sat_below", 64'(sa_if.conflict_cnt_o[WEST]), 64'd65532);
        @(posedge clk);
        #1;
        check_output("sat_hit", 64'(sa_if.conflict_cnt_o[WEST]), 64'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check_output("sat_hold", 64'(sa_if.conflict_cnt_o[WEST]), 64'hFFFF);
        drive(blank(1'b0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
